// File: rtl/redmule_x_pad_ctrl.sv
// X pad SCM sequencer: fills a zero-padded ROWS x COLS tile row by row from the input stream,
// then drains it column by column to the X feeder with a one-cycle SCM read latency.
module redmule_x_pad_ctrl #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic [$clog2(ROWS+1)-1:0]     tile_rows_i,
    input  logic [$clog2(COLS+1)-1:0]     tile_cols_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [COLS*WORD_SIZE-1:0]     in_data_i,
    output logic                          buf_clear_o,
    output logic                          buf_write_en_o,
    output logic [$clog2(ROWS)-1:0]       buf_write_addr_o,
    output logic [COLS*WORD_SIZE-1:0]     buf_wdata_o,
    output logic                          buf_read_en_o,
    output logic [$clog2(COLS)-1:0]       buf_read_addr_o,
    input  logic [ROWS*WORD_SIZE-1:0]     buf_rdata_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [ROWS*WORD_SIZE-1:0]     out_data_o,
    output logic                          out_last_o,
    output logic                          busy_o,
    output logic                          done_o
);
    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned CW  = $clog2(COLS);
    localparam int unsigned TRW = $clog2(ROWS+1);
    localparam int unsigned TCW = $clog2(COLS+1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS-1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS-1);

    // state | meaning: IDLE wait start | FILL write input rows | PAD write zero rows | DRAIN read columns
    typedef enum logic [1:0] {IDLE, FILL, PAD, DRAIN} state_t;

    state_t        r_state;
    logic [RW-1:0] r_row;
    logic [RW-1:0] r_rows_m1;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_cols_m1;
    logic [CW-1:0] r_out_col;
    logic          r_arm;
    logic          r_rd_done;
    logic          r_out_valid;
    logic          r_done;

    logic                      w_start;
    logic                      w_in_hs;
    logic                      w_rd_en;
    logic                      w_out_hs;
    logic                      w_out_last;
    logic [RW-1:0]             w_rows_m1;
    logic [CW-1:0]             w_cols_m1;
    logic [COLS*WORD_SIZE-1:0] w_wdata_masked;

    assign w_start   = (r_state == IDLE) && start_i;
    assign w_rows_m1 = (tile_rows_i == '0 || tile_rows_i > TRW'(ROWS)) ? ROW_MAX
                                                                      : RW'(tile_rows_i - TRW'(1));
    assign w_cols_m1 = (tile_cols_i == '0 || tile_cols_i > TCW'(COLS)) ? COL_MAX
                                                                      : CW'(tile_cols_i - TCW'(1));

    always_comb begin
        w_wdata_masked = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (CW'(c) <= r_cols_m1)
                w_wdata_masked[c*WORD_SIZE +: WORD_SIZE] = in_data_i[c*WORD_SIZE +: WORD_SIZE];
        end
    end

    // r_arm keeps the first read one cycle clear of the final write
    assign w_in_hs    = (r_state == FILL) && in_valid_i && !clear_i;
    assign w_rd_en    = (r_state == DRAIN) && r_arm && !r_rd_done && !clear_i
                        && (!r_out_valid || out_ready_i);
    assign w_out_hs   = r_out_valid && out_ready_i;
    assign w_out_last = r_out_valid && (r_out_col == r_cols_m1);

    assign in_ready_o       = (r_state == FILL) && !clear_i;
    assign buf_clear_o      = clear_i || w_start;
    assign buf_write_en_o   = w_in_hs || ((r_state == PAD) && !clear_i);
    assign buf_write_addr_o = r_row;
    assign buf_wdata_o      = (r_state == FILL) ? w_wdata_masked : '0;
    assign buf_read_en_o    = w_rd_en;
    assign buf_read_addr_o  = r_col;
    assign out_valid_o      = r_out_valid;
    assign out_data_o       = (r_state == DRAIN) ? buf_rdata_i : '0;
    assign out_last_o       = w_out_last;
    assign busy_o           = (r_state != IDLE);
    assign done_o           = r_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_out_col   <= '0;
            r_rows_m1   <= ROW_MAX;
            r_cols_m1   <= COL_MAX;
            r_arm       <= 1'b0;
            r_rd_done   <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clear_i) begin
                r_state     <= IDLE;
                r_row       <= '0;
                r_col       <= '0;
                r_arm       <= 1'b0;
                r_rd_done   <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start_i) begin
                            r_rows_m1 <= w_rows_m1;
                            r_cols_m1 <= w_cols_m1;
                            r_state   <= FILL;
                        end
                    end
                    FILL: begin
                        if (w_in_hs) begin
                            if (r_row == r_rows_m1 && r_rows_m1 == ROW_MAX) begin
                                r_row   <= '0;
                                r_state <= DRAIN;
                            end else begin
                                r_row <= r_row + RW'(1);
                                if (r_row == r_rows_m1)
                                    r_state <= PAD;
                            end
                        end
                    end
                    PAD: begin
                        if (r_row == ROW_MAX) begin
                            r_row   <= '0;
                            r_state <= DRAIN;
                        end else begin
                            r_row <= r_row + RW'(1);
                        end
                    end
                    DRAIN: begin
                        r_arm <= 1'b1;
                        if (w_rd_en) begin
                            r_out_valid <= 1'b1;
                            r_out_col   <= r_col;
                            if (r_col == r_cols_m1)
                                r_rd_done <= 1'b1;
                            else
                                r_col <= r_col + CW'(1);
                        end else if (w_out_hs) begin
                            r_out_valid <= 1'b0;
                        end
                        if (w_out_hs && w_out_last) begin
                            r_state     <= IDLE;
                            r_col       <= '0;
                            r_arm       <= 1'b0;
                            r_rd_done   <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_redmule_x_pad_ctrl.sv
// Bench for redmule_x_pad_ctrl: table of tile shapes driven through a behavioural SCM,
// plus hand-written clear-mid-drain and reset-mid-fill sequences.
module tb_redmule_x_pad_ctrl;
    localparam int W   = 16;
    localparam int R   = 4;
    localparam int C   = 4;
    localparam int TRW = $clog2(R+1);
    localparam int TCW = $clog2(C+1);

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 clear_i = 1'b0;
    logic                 start_i = 1'b0;
    logic [TRW-1:0]       tile_rows_i = '0;
    logic [TCW-1:0]       tile_cols_i = '0;
    logic                 in_valid_i = 1'b0;
    logic                 in_ready_o;
    logic [C*W-1:0]       in_data_i = '0;
    logic                 buf_clear_o;
    logic                 buf_write_en_o;
    logic [$clog2(R)-1:0] buf_write_addr_o;
    logic [C*W-1:0]       buf_wdata_o;
    logic                 buf_read_en_o;
    logic [$clog2(C)-1:0] buf_read_addr_o;
    logic [R*W-1:0]       buf_rdata_i = '0;
    logic                 out_valid_o;
    logic                 out_ready_i = 1'b1;
    logic [R*W-1:0]       out_data_o;
    logic                 out_last_o;
    logic                 busy_o;
    logic                 done_o;

    int checks = 0;
    int failures = 0;

    redmule_x_pad_ctrl #(.WORD_SIZE(W), .ROWS(R), .COLS(C)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .tile_rows_i(tile_rows_i), .tile_cols_i(tile_cols_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .buf_clear_o(buf_clear_o), .buf_write_en_o(buf_write_en_o),
        .buf_write_addr_o(buf_write_addr_o), .buf_wdata_o(buf_wdata_o),
        .buf_read_en_o(buf_read_en_o), .buf_read_addr_o(buf_read_addr_o),
        .buf_rdata_i(buf_rdata_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Behavioural SCM: row-wide writes, column-wide reads with one cycle of latency
    logic [C*W-1:0] mem [R];
    always @(posedge clk) begin
        if (buf_clear_o) begin
            for (int r = 0; r < R; r++) mem[r] <= '0;
        end else if (buf_write_en_o) begin
            mem[buf_write_addr_o] <= buf_wdata_o;
        end
        if (buf_read_en_o) begin
            for (int r = 0; r < R; r++) buf_rdata_i[r*W +: W] <= mem[r][buf_read_addr_o*W +: W];
        end
    end

    typedef struct {
        logic [TRW-1:0] tr;
        logic [TCW-1:0] tc;
        int             gap;
        logic [7:0]     rdy;
        int             clr;
        int             exp_rows;
        int             exp_cols;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [C*W-1:0] row_data(input int r);
        logic [C*W-1:0] d;
        d = '0;
        for (int c = 0; c < C; c++) d[c*W +: W] = {8'(r), 8'(c)};
        return d;
    endfunction

    function automatic logic [C*W-1:0] row_masked(input int r, input int cols);
        logic [C*W-1:0] d;
        d = '0;
        for (int c = 0; c < C; c++) if (c < cols) d[c*W +: W] = {8'(r), 8'(c)};
        return d;
    endfunction

    function automatic logic [R*W-1:0] exp_beat(input int c, input int rows);
        logic [R*W-1:0] d;
        d = '0;
        for (int r = 0; r < R; r++) if (r < rows) d[r*W +: W] = {8'(r), 8'(c)};
        return d;
    endfunction

    task automatic run_tile(input vec_t v);
        int row = 0, gap_cnt = 0, wr_idx = 0, pads = 0, rd_idx = 0, beat = 0;
        int cyc = 0, k = 0, last_cyc = -10, prev_hs = -10;
        bit seen = 0, fin = 0, prev_stall = 0;
        logic [R*W-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        tile_rows_i = v.tr;
        tile_cols_i = v.tc;
        #1;
        chk("start_buf_clear", 64'(buf_clear_o), 64'd1);
        chk("idle_in_ready", 64'(in_ready_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        while (!fin && cyc < 300) begin
            in_valid_i = (row < v.exp_rows) && (gap_cnt == 0);
            in_data_i = row_data(row);
            if (out_valid_o) seen = 1;
            out_ready_i = seen ? v.rdy[k % 8] : 1'b1;
            #1;
            chk("done_o", 64'(done_o), 64'(cyc == last_cyc + 1));
            if (prev_stall) begin
                chk("stall_data", out_data_o, prev_data);
                chk("stall_last", 64'(out_last_o), 64'(prev_last));
                chk("stall_valid", 64'(out_valid_o), 64'd1);
            end
            if (out_valid_o && !out_ready_i) chk("rd_en_in_stall", 64'(buf_read_en_o), 64'd0);
            if (in_valid_i && in_ready_o) begin
                chk("fill_write_en", 64'(buf_write_en_o), 64'd1);
                row++;
                gap_cnt = v.gap;
            end else if (gap_cnt > 0) begin
                gap_cnt--;
            end
            if (buf_write_en_o) begin
                chk("wr_addr", 64'(buf_write_addr_o), 64'(wr_idx));
                chk("wr_data", 64'(buf_wdata_o),
                    64'(wr_idx < v.exp_rows ? row_masked(wr_idx, v.exp_cols) : '0));
                if (!in_valid_i) pads++;
                wr_idx++;
            end
            if (buf_read_en_o) begin
                chk("rd_addr", 64'(buf_read_addr_o), 64'(rd_idx));
                rd_idx++;
            end
            if (out_valid_o && out_ready_i) begin
                chk("beat_data", out_data_o, exp_beat(beat, v.exp_rows));
                chk("beat_last", 64'(out_last_o), 64'(beat == v.exp_cols - 1));
                if (v.rdy == 8'hFF && beat > 0) chk("throughput", 64'(cyc), 64'(prev_hs + 1));
                prev_hs = cyc;
                if (out_last_o) last_cyc = cyc;
                beat++;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data = out_data_o;
            prev_last = out_last_o;
            if (seen) k++;
            if (cyc == last_cyc + 1) begin
                chk("done_busy", 64'(busy_o), 64'd0);
                fin = 1;
            end
            if (v.clr != 0 && beat == v.clr) fin = 1;
            @(negedge clk);
            cyc++;
        end
        in_valid_i = 1'b0;
        chk("no_timeout", 64'(cyc < 300), 64'd1);
        chk("n_writes", 64'(wr_idx), 64'(R));
        chk("n_pads", 64'(pads), 64'(R - v.exp_rows));
        if (v.clr == 0) begin
            chk("n_beats", 64'(beat), 64'(v.exp_cols));
            chk("n_reads", 64'(rd_idx), 64'(v.exp_cols));
        end else begin
            clear_i = 1'b1;
            out_ready_i = 1'b0;
            #1;
            chk("clr_buf_clear", 64'(buf_clear_o), 64'd1);
            chk("clr_inflight_valid", 64'(out_valid_o), 64'd1);
            @(negedge clk);
            clear_i = 1'b0;
            out_ready_i = 1'b1;
            #1;
            chk("clr_busy", 64'(busy_o), 64'd0);
            chk("clr_out_valid", 64'(out_valid_o), 64'd0);
            chk("clr_done", 64'(done_o), 64'd0);
            repeat (2) begin
                @(negedge clk);
                #1;
                chk("clr_no_done", 64'(done_o), 64'd0);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready_o), 64'd0);
        chk({tag, "_we"}, 64'(buf_write_en_o), 64'd0);
        chk({tag, "_waddr"}, 64'(buf_write_addr_o), 64'd0);
        chk({tag, "_wdata"}, 64'(buf_wdata_o), 64'd0);
        chk({tag, "_re"}, 64'(buf_read_en_o), 64'd0);
        chk({tag, "_raddr"}, 64'(buf_read_addr_o), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last_o), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
    endtask

    initial begin
        //           tr    tc    gap rdy              clr rows cols
        vecs[0] = '{3'd0, 3'd0, 0, 8'hFF,          0,  4,   4};
        vecs[1] = '{3'd2, 3'd3, 0, 8'hFF,          0,  2,   3};
        vecs[2] = '{3'd4, 3'd4, 0, 8'b1110_1001,   0,  4,   4};
        vecs[3] = '{3'd4, 3'd0, 3, 8'hFF,          0,  4,   4};
        vecs[4] = '{3'd3, 3'd1, 1, 8'b1111_1110,   0,  3,   1};
        vecs[5] = '{3'd4, 3'd4, 0, 8'hFF,          2,  4,   4};
        vecs[6] = '{3'd1, 3'd2, 0, 8'hFF,          0,  1,   2};

        #2;
        chk_reset_outputs("por");
        chk("por_buf_clear", 64'(buf_clear_o), 64'd0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_tile(vecs[i]);

        // Asynchronous reset in the middle of FILL, two rows already written
        @(negedge clk);
        start_i = 1'b1;
        tile_rows_i = '0;
        tile_cols_i = '0;
        @(negedge clk);
        start_i = 1'b0;
        in_valid_i = 1'b1;
        in_data_i = row_data(0);
        @(negedge clk);
        in_data_i = row_data(1);
        #1;
        chk("mid_fill_busy", 64'(busy_o), 64'd1);
        chk("mid_fill_waddr", 64'(buf_write_addr_o), 64'd1);
        @(posedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        in_valid_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        run_tile(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
